// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and default width for serial_subtractor
package serial_subtractor_pkg;

    localparam int SS_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit full subtractor built from two half-subtractor cells
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d1;
    logic hb1;
    logic hb2;

    // First half-subtractor handles a - b, second subtracts the incoming borrow.
    assign d1   = a ^ b;
    assign hb1  = ~a & b;
    assign diff = d1 ^ bin;
    assign hb2  = ~d1 & bin;
    assign bout = hb1 | hb2;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with start/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             busy_q;
    logic             done_q;

    logic             bit_d;
    logic             bit_b;

    full_subtractor u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (borrow_q),
        .diff (bit_d),
        .bout (bit_b)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                diff_d   = {bit_d, diff_q[WIDTH-1:1]};
                borrow_d = bit_b;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = cnt_q;
                    bout_d  = bit_b;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= (state_d == S_RUN);
            done_q   <= (state_d == S_FIN);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor and full_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    logic         fa = 1'b0;
    logic         fb = 1'b0;
    logic         fbin = 1'b0;
    logic         fdiff;
    logic         fbout;

    int vectors = 0;
    int miscompares = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    full_subtractor fs (
        .a    (fa),
        .b    (fb),
        .bin  (fbin),
        .diff (fdiff),
        .bout (fbout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k = edges since the accepted start (E0 counts as 1); 0 means idle.
    int k = 0;
    int res = 0;
    int res_b = 0;
    int held = 0;
    int held_b = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0; held = 0; held_b = 0;
        end else if (k == 0) begin
            if (start) begin
                res   = (int'(a) - int'(b)) & ((1 << W) - 1);
                res_b = (a < b) ? 1 : 0;
                k     = 1;
            end
        end else if (k == W + 1) begin
            k = 0;
        end else begin
            k++;
            if (k == W + 1) begin
                held   = res;
                held_b = res_b;
            end
        end
    end

    always @(negedge clk) begin
        int exp_diff;
        int j;
        exp_diff = held;
        if (k >= 2 && k <= W) begin
            j = k - 1;
            exp_diff = (((res & ((1 << j) - 1)) << (W - j)) | (held >> j)) & ((1 << W) - 1);
        end
        check("busy", int'(busy), (k >= 1 && k <= W) ? 1 : 0);
        check("done", int'(done), (k == W + 1) ? 1 : 0);
        check("diff", int'(diff), exp_diff);
        check("bout", int'(bout), held_b);
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int exp_d, input int exp_b, input int check_timing);
        int n;
        int nbusy;
        bit seen;
        @(posedge clk); #2;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; nbusy = 0; seen = 0;
        if (busy) nbusy++;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (busy) nbusy++;
            if (done) seen = 1;
        end
        check("done_seen", int'(seen), 1);
        if (check_timing != 0) begin
            check("latency_edges", n, 9);
            check("busy_cycles", nbusy, 8);
        end
        check("op_diff", int'(diff), exp_d);
        check("op_bout", int'(bout), exp_b);
        @(posedge clk); #1;
        check("done_single", int'(done), 0);
    endtask

    initial begin
        int ndone;
        int first_idx;
        int last_idx;
        int r;
        int waited;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
        #1 rst = 1'b0;

        run_op(8'h05, 8'h03, 8'h02, 0, 1);
        run_op(8'h03, 8'h05, 8'hFE, 1, 0);
        run_op(8'h00, 8'h01, 8'hFF, 1, 0);
        run_op(8'h80, 8'h80, 8'h00, 0, 0);

        // Second start mid-RUN with new operands must be ignored.
        @(posedge clk); #2;
        a = 8'hFF; b = 8'h0F; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("ign_diff", int'(diff), 8'hF0);
                check("ign_bout", int'(bout), 0);
            end
        end
        check("ign_done_count", ndone, 1);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        @(posedge clk); #2;
        a = 8'h10; b = 8'h01; start = 1'b1;
        ndone = 0; first_idx = -1; last_idx = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first_idx < 0) first_idx = i;
                else check("b2b_spacing", i - last_idx, 10);
                last_idx = i;
                check("b2b_diff", int'(diff), 8'h0F);
            end
        end
        #1 start = 1'b0;
        check("b2b_done_count", ndone, 3);
        check("b2b_first_done", first_idx, 8);
        waited = 0;
        while ((busy || done) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("b2b_drain", int'(busy || done), 0);

        // Asynchronous reset during the 4th RUN cycle.
        @(posedge clk); #2;
        a = 8'hAA; b = 8'h11; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_diff", int'(diff), 0);
        check("arst_bout", int'(bout), 0);
        @(posedge clk); #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("arst_no_done", ndone, 0);
        run_op(8'h64, 8'h32, 8'h32, 0, 0);

        for (int i = 0; i < 8; i++) begin
            fa = i[2]; fb = i[1]; fbin = i[0];
            #1;
            r = int'(fa) - int'(fb) - int'(fbin);
            check("fs_diff", int'(fdiff), r & 1);
            check("fs_bout", int'(fbout), (r < 0) ? 1 : 0);
        end
        check("fs_lit_011", ((0 - 1 - 1) < 0) ? 1 : 0, int'(1'b1) & int'(fbout | 1'b1));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

endmodule
